// File: rtl/fifo_tap_line.sv
// Eight-deep sample delay line feeding the FIR taps.
// Circular buffer plus write pointer; taps are muxed out relative to the pointer.
module fifo_tap_line #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic [15:0]       w,
    output logic [DATA_W-1:0] A0,
    output logic [DATA_W-1:0] A1,
    output logic [DATA_W-1:0] A2,
    output logic [DATA_W-1:0] A3,
    output logic [DATA_W-1:0] A4,
    output logic [DATA_W-1:0] A5,
    output logic [DATA_W-1:0] A6,
    output logic [DATA_W-1:0] A7
);

    logic [DATA_W-1:0] mem [8];
    logic [2:0]        wp;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < 8; i++) begin
                mem[i] <= '0;
            end
            wp <= '0;
        end else if (enable) begin
            mem[wp] <= w[DATA_W-1:0];
            wp      <= wp + 3'd1;
        end
    end

    // wp names the next slot to write, so the newest sample sits one behind it.
    assign A0 = mem[wp - 3'd1];
    assign A1 = mem[wp - 3'd2];
    assign A2 = mem[wp - 3'd3];
    assign A3 = mem[wp - 3'd4];
    assign A4 = mem[wp - 3'd5];
    assign A5 = mem[wp - 3'd6];
    assign A6 = mem[wp - 3'd7];
    assign A7 = mem[wp];

endmodule

// File: tb/tb_fifo_tap_line.sv
// Self-checking bench for fifo_tap_line: vector table, hand sequences,
// and random traffic compared against a queue-based delay-line model.
module tb_fifo_tap_line;

    logic        clk;
    logic        resetn;
    logic        enable;
    logic [15:0] w;
    logic [7:0]  A0, A1, A2, A3, A4, A5, A6, A7;
    logic [7:0][7:0] taps;

    int checks = 0;
    int passes = 0;

    logic [7:0] mdl [$];

    typedef struct {
        logic            rstn;
        logic            en;
        logic [15:0]     win;
        logic [7:0][7:0] exp;
        string           name;
    } vec_t;

    vec_t vecs [12];

    fifo_tap_line #(.DATA_W(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .enable (enable),
        .w      (w),
        .A0     (A0),
        .A1     (A1),
        .A2     (A2),
        .A3     (A3),
        .A4     (A4),
        .A5     (A5),
        .A6     (A6),
        .A7     (A7)
    );

    assign taps = {A7, A6, A5, A4, A3, A2, A1, A0};

    always #5 clk = ~clk;

    function automatic logic [7:0][7:0] model_taps();
        logic [7:0][7:0] r;
        for (int k = 0; k < 8; k++) r[k] = mdl[k];
        return r;
    endfunction

    // Reference: newest at the front, oldest falls off the back.
    task automatic model_clear();
        mdl = {};
        for (int k = 0; k < 8; k++) mdl.push_back(8'h00);
    endtask

    task automatic step(input logic r, input logic e, input logic [15:0] ww);
        @(negedge clk);
        resetn = r;
        enable = e;
        w      = ww;
        @(posedge clk);
        if (!r) begin
            model_clear();
        end else if (e) begin
            mdl.push_front(ww[7:0]);
            void'(mdl.pop_back());
        end
        #1;
    endtask

    task automatic check(input string name, input logic [7:0][7:0] exp);
        checks++;
        if (taps === exp) passes++;
        else $display("FAIL %s: taps(A7..A0)=%h expected=%h", name, taps, exp);
    endtask

    logic [7:0][7:0] prev;

    initial begin
        clk    = 1'b0;
        resetn = 1'b0;
        enable = 1'b0;
        w      = 16'h0000;
        model_clear();

        vecs[0]  = '{1'b0, 1'b1, 16'hC3A5, 64'h0,                      "reset_edge1"};
        vecs[1]  = '{1'b0, 1'b1, 16'h1234, 64'h0,                      "reset_edge2"};
        vecs[2]  = '{1'b1, 1'b1, 16'h5A01, 64'h00000000_00000001,      "fill1"};
        vecs[3]  = '{1'b1, 1'b1, 16'h5A02, 64'h00000000_00000102,      "fill2"};
        vecs[4]  = '{1'b1, 1'b1, 16'h5A03, 64'h00000000_00010203,      "fill3"};
        vecs[5]  = '{1'b1, 1'b1, 16'h5A04, 64'h00000000_01020304,      "fill4"};
        vecs[6]  = '{1'b1, 1'b1, 16'h5A05, 64'h00000001_02030405,      "fill5"};
        vecs[7]  = '{1'b1, 1'b1, 16'h5A06, 64'h00000102_03040506,      "fill6"};
        vecs[8]  = '{1'b1, 1'b1, 16'h5A07, 64'h00010203_04050607,      "fill7"};
        vecs[9]  = '{1'b1, 1'b1, 16'h5A08, 64'h01020304_05060708,      "fill8"};
        vecs[10] = '{1'b1, 1'b1, 16'hFF09, 64'h02030405_06070809,      "evict9"};
        vecs[11] = '{1'b1, 1'b1, 16'hFF0A, 64'h03040506_0708090A,      "evict10"};

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rstn, vecs[i].en, vecs[i].win);
            check(vecs[i].name, vecs[i].exp);
        end

        for (int i = 0; i < 128; i++) begin
            step(1'b1, 1'b1, 16'($urandom));
            check("random_dense", model_taps());
        end

        prev = model_taps();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 16'($urandom));
            check("hold", prev);
        end

        step(1'b1, 1'b1, 16'hAB12);
        check("byte_select", {prev[6:0], 8'h12});

        step(1'b0, 1'b1, 16'h0055);
        check("reset_priority", 64'h0);
        step(1'b1, 1'b1, 16'h0077);
        check("post_reset_write", 64'h00000000_00000077);

        for (int i = 0; i < 128 * 16; i++) begin
            step(1'b1, (i % 16) == 15, 16'($urandom));
            check("sparse", model_taps());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
